// File: rtl/comparator_sliced_seq.sv
// Multi-cycle magnitude comparator: walks the operands MSB slice first and stops on the first unequal slice.
// Optional two's-complement ordering is enabled by defining COMPARATOR_SIGNED_MODE_EN.
module comparator_sliced_seq #(
    parameter int DATA_WIDTH  = 32,
    parameter int SLICE_WIDTH = 8
) (
    input  logic                                           Clock_In,
    input  logic                                           Reset_In,
    input  logic                                           Start_In,
    input  logic [DATA_WIDTH-1:0]                          Data_A_In,
    input  logic [DATA_WIDTH-1:0]                          Data_B_In,
    input  logic                                           Signed_Mode_In,
    output logic                                           Busy_Out,
    output logic                                           Done_Out,
    output logic                                           A_Less_Than_B_Out,
    output logic                                           A_Equal_To_B_Out,
    output logic                                           A_Greater_Than_B_Out,
    output logic [$clog2(DATA_WIDTH/SLICE_WIDTH+1)-1:0]    Slices_Used_Out
);

    localparam int NUM_SLICES = DATA_WIDTH / SLICE_WIDTH;
    localparam int CNT_W      = $clog2(NUM_SLICES + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t                  state, state_next;
    logic [DATA_WIDTH-1:0]   a_reg, b_reg;
    logic [CNT_W-1:0]        slice_cnt;
    logic [SLICE_WIDTH-1:0]  a_top, b_top;
    logic                    last_slice;
    logic                    accept;
    logic                    sign_flip;

`ifdef COMPARATOR_SIGNED_MODE_EN
    assign sign_flip = Signed_Mode_In;
`else
    logic unused_signed_mode;
    assign unused_signed_mode = Signed_Mode_In;
    assign sign_flip          = 1'b0;
`endif

    // Operands shift left each cycle, so the slice under test is always the top one.
    // Inverting the operand MSB at capture gives offset-binary, i.e. signed ordering.
    assign a_top      = a_reg[DATA_WIDTH-1 -: SLICE_WIDTH];
    assign b_top      = b_reg[DATA_WIDTH-1 -: SLICE_WIDTH];
    assign last_slice = (slice_cnt == CNT_W'(NUM_SLICES - 1));
    assign accept     = Start_In && (state != COMPARE);

    assign Busy_Out = (state == COMPARE);
    assign Done_Out = (state == DONE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: defaults first so no path through this block leaves state_next unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                state_next = accept ? COMPARE : IDLE;
            end
            COMPARE: begin
                if (a_top != b_top || last_slice) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            a_reg                <= '0;
            b_reg                <= '0;
            slice_cnt            <= '0;
            A_Less_Than_B_Out    <= 1'b0;
            A_Equal_To_B_Out     <= 1'b0;
            A_Greater_Than_B_Out <= 1'b0;
            Slices_Used_Out      <= '0;
        end else if (accept) begin
            a_reg                <= Data_A_In ^ {sign_flip, {(DATA_WIDTH-1){1'b0}}};
            b_reg                <= Data_B_In ^ {sign_flip, {(DATA_WIDTH-1){1'b0}}};
            slice_cnt            <= '0;
            A_Less_Than_B_Out    <= 1'b0;
            A_Equal_To_B_Out     <= 1'b0;
            A_Greater_Than_B_Out <= 1'b0;
            Slices_Used_Out      <= '0;
        end else if (state == COMPARE) begin
            if (a_top < b_top) begin
                A_Less_Than_B_Out <= 1'b1;
                Slices_Used_Out   <= slice_cnt + CNT_W'(1);
            end else if (a_top > b_top) begin
                A_Greater_Than_B_Out <= 1'b1;
                Slices_Used_Out      <= slice_cnt + CNT_W'(1);
            end else if (last_slice) begin
                A_Equal_To_B_Out <= 1'b1;
                Slices_Used_Out  <= CNT_W'(NUM_SLICES);
            end else begin
                a_reg     <= a_reg << SLICE_WIDTH;
                b_reg     <= b_reg << SLICE_WIDTH;
                slice_cnt <= slice_cnt + CNT_W'(1);
            end
        end
    end

endmodule
